vga_frame_reader: RTL and testbench

//  Read side of the QVGA frame buffer: scans the 320x240 RGB565 buffer filled by the camera capture path.

---
 rtl/vga_frame_reader_if.sv | 9 +
 rtl/vga_frame_reader.sv | 162 ++++++++++++++++
 tb/tb_vga_frame_reader.sv | 301 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/vga_frame_reader_if.sv
// Frame buffer read port: the reader drives oe/rAddr, the buffer answers with rData one pclk later.
interface vga_frame_reader_if;
  logic        oe;
  logic [16:0] rAddr;
  logic [15:0] rData;

  modport master (output oe, output rAddr, input rData);
  modport slave  (input oe, input rAddr, output rData);
endinterface

// File: rtl/vga_frame_reader.sv
// Scans the 320x240 RGB565 frame buffer out as 640x480@60 VGA with 2x pixel/line duplication.
// Counters address the buffer directly; sync, DE and position ride a 2-stage pipeline alongside the read data.
module vga_frame_reader #(
  parameter int H_VISIBLE = 640,
  parameter int H_FP      = 16,
  parameter int H_SYNC    = 96,
  parameter int H_BP      = 48,
  parameter int V_VISIBLE = 480,
  parameter int V_FP      = 10,
  parameter int V_SYNC    = 2,
  parameter int V_BP      = 33
) (
  input  logic               pclk,
  input  logic               reset_n,
  vga_frame_reader_if.master fb,
  output logic               h_sync,
  output logic               v_sync,
  output logic               de,
  output logic [9:0]         x_pixel,
  output logic [9:0]         y_pixel,
  output logic [3:0]         red,
  output logic [3:0]         green,
  output logic [3:0]         blue,
  output logic               frame_start
);

  localparam int H_TOTAL = H_VISIBLE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_VISIBLE + V_FP + V_SYNC + V_BP;

  localparam logic [9:0] H_ACT      = 10'(H_VISIBLE);
  localparam logic [9:0] H_LAST     = 10'(H_TOTAL - 1);
  localparam logic [9:0] HS_FIRST   = 10'(H_VISIBLE + H_FP);
  localparam logic [9:0] HS_LAST    = 10'(H_VISIBLE + H_FP + H_SYNC - 1);
  localparam logic [9:0] V_ACT      = 10'(V_VISIBLE);
  localparam logic [9:0] V_LAST     = 10'(V_TOTAL - 1);
  localparam logic [9:0] VS_FIRST   = 10'(V_VISIBLE + V_FP);
  localparam logic [9:0] VS_LAST    = 10'(V_VISIBLE + V_FP + V_SYNC - 1);

  logic        run_q, run_d;
  logic [9:0]  h_cnt_q, h_cnt_d;
  logic [9:0]  v_cnt_q, v_cnt_d;

  logic        active;
  logic        hs_raw, vs_raw, fs_raw;
  logic [8:0]  row, col;
  logic [16:0] addr;

  logic        act1_q, act1_d;
  logic        hs1_q, hs1_d;
  logic        vs1_q, vs1_d;
  logic        fs1_q, fs1_d;
  logic [9:0]  x1_q, x1_d;
  logic [9:0]  y1_q, y1_d;

  logic        de_q, de_d;
  logic        h_sync_q, h_sync_d;
  logic        v_sync_q, v_sync_d;
  logic        frame_start_q, frame_start_d;
  logic [9:0]  x_pixel_q, x_pixel_d;
  logic [9:0]  y_pixel_q, y_pixel_d;
  logic [3:0]  red_q, red_d;
  logic [3:0]  green_q, green_d;
  logic [3:0]  blue_q, blue_d;

  // run_q holds the scan at (0,0) for the first edge after reset release, so that
  // pixel (0,0) is read on the first cycle and oe stays low while reset is asserted.
  always_comb begin
    run_d   = 1'b1;
    h_cnt_d = h_cnt_q;
    v_cnt_d = v_cnt_q;
    if (run_q) begin
      if (h_cnt_q == H_LAST) begin
        h_cnt_d = '0;
        v_cnt_d = (v_cnt_q == V_LAST) ? '0 : v_cnt_q + 10'd1;
      end else begin
        h_cnt_d = h_cnt_q + 10'd1;
      end
    end

    active = run_q && (h_cnt_q < H_ACT) && (v_cnt_q < V_ACT);
    hs_raw = !(run_q && (h_cnt_q >= HS_FIRST) && (h_cnt_q <= HS_LAST));
    vs_raw = !(run_q && (v_cnt_q >= VS_FIRST) && (v_cnt_q <= VS_LAST));
    fs_raw = run_q && (h_cnt_q == '0) && (v_cnt_q == '0);

    // Halving both counters gives the 2x duplication; row*320 = (row<<8)+(row<<6).
    row  = v_cnt_q[9:1];
    col  = h_cnt_q[9:1];
    addr = active ? ({row, 8'b0} + 17'({row, 6'b0}) + 17'(col)) : '0;

    act1_d = active;
    hs1_d  = hs_raw;
    vs1_d  = vs_raw;
    fs1_d  = fs_raw;
    x1_d   = h_cnt_q;
    y1_d   = v_cnt_q;

    de_d          = act1_q;
    h_sync_d      = hs1_q;
    v_sync_d      = vs1_q;
    frame_start_d = fs1_q;
    x_pixel_d     = x1_q;
    y_pixel_d     = y1_q;
    red_d         = act1_q ? fb.rData[15:12] : 4'h0;
    green_d       = act1_q ? fb.rData[10:7]  : 4'h0;
    blue_d        = act1_q ? fb.rData[4:1]   : 4'h0;
  end

  always_ff @(posedge pclk or negedge reset_n) begin
    if (!reset_n) begin
      run_q         <= 1'b0;
      h_cnt_q       <= '0;
      v_cnt_q       <= '0;
      act1_q        <= 1'b0;
      hs1_q         <= 1'b1;
      vs1_q         <= 1'b1;
      fs1_q         <= 1'b0;
      x1_q          <= '0;
      y1_q          <= '0;
      de_q          <= 1'b0;
      h_sync_q      <= 1'b1;
      v_sync_q      <= 1'b1;
      frame_start_q <= 1'b0;
      x_pixel_q     <= '0;
      y_pixel_q     <= '0;
      red_q         <= '0;
      green_q       <= '0;
      blue_q        <= '0;
    end else begin
      run_q         <= run_d;
      h_cnt_q       <= h_cnt_d;
      v_cnt_q       <= v_cnt_d;
      act1_q        <= act1_d;
      hs1_q         <= hs1_d;
      vs1_q         <= vs1_d;
      fs1_q         <= fs1_d;
      x1_q          <= x1_d;
      y1_q          <= y1_d;
      de_q          <= de_d;
      h_sync_q      <= h_sync_d;
      v_sync_q      <= v_sync_d;
      frame_start_q <= frame_start_d;
      x_pixel_q     <= x_pixel_d;
      y_pixel_q     <= y_pixel_d;
      red_q         <= red_d;
      green_q       <= green_d;
      blue_q        <= blue_d;
    end
  end

  assign fb.oe       = active;
  assign fb.rAddr    = addr;
  assign h_sync      = h_sync_q;
  assign v_sync      = v_sync_q;
  assign de          = de_q;
  assign x_pixel     = x_pixel_q;
  assign y_pixel     = y_pixel_q;
  assign red         = red_q;
  assign green       = green_q;
  assign blue        = blue_q;
  assign frame_start = frame_start_q;

endmodule

// File: tb/tb_vga_frame_reader.sv
// Directed bench for vga_frame_reader; vertical timing is shortened (8 visible lines, 15 total)
// so whole frames fit in a short run while horizontal timing and addressing stay at 640x480 values.
module tb_vga_frame_reader;

  localparam int V_VIS = 8;
  localparam int V_FPR = 2;
  localparam int V_SYN = 2;
  localparam int V_BPR = 3;
  localparam int FRAME = 800 * (V_VIS + V_FPR + V_SYN + V_BPR);

  logic       pclk = 1'b0;
  logic       reset_n = 1'b0;
  logic       h_sync, v_sync, de, frame_start;
  logic [9:0] x_pixel, y_pixel;
  logic [3:0] red, green, blue;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int mem_mode = 0;

  vga_frame_reader_if fb ();

  vga_frame_reader #(
    .V_VISIBLE(V_VIS), .V_FP(V_FPR), .V_SYNC(V_SYN), .V_BP(V_BPR)
  ) dut (
    .pclk(pclk), .reset_n(reset_n), .fb(fb),
    .h_sync(h_sync), .v_sync(v_sync), .de(de),
    .x_pixel(x_pixel), .y_pixel(y_pixel),
    .red(red), .green(green), .blue(blue),
    .frame_start(frame_start)
  );

  always #20 pclk = ~pclk;

  // Synchronous frame buffer model: data appears one pclk after the read.
  always @(posedge pclk) begin
    case (mem_mode)
      1:       fb.rData <= 16'hF81F;
      2:       fb.rData <= 16'hFFFF;
      default: fb.rData <= fb.oe ? fb.rAddr[15:0] : 16'h0000;
    endcase
  end

  // Leaves the bench at the negedge of cycle 0 (first cycle after release), cyc = 0.
  task automatic start_scan();
    reset_n = 1'b0;
    repeat (3) @(negedge pclk);
    reset_n = 1'b1;
    @(posedge pclk);
    @(negedge pclk);
    cyc = 0;
  endtask

  task automatic go_to(input int target);
    while (cyc < target) begin
      @(negedge pclk);
      cyc++;
    end
  endtask

  task automatic test_reset();
    mem_mode = 0;
    start_scan();
    go_to(300);
    total++;
    if (de !== 1'b1) begin bad++; $display("[TB] FAIL reset_pre_de got=%0b exp=1", de); end
    reset_n = 1'b0;
    #1;
    total++;
    if ({fb.oe, de, h_sync, v_sync, red, green, blue} !== {1'b0, 1'b0, 1'b1, 1'b1, 12'h000}) begin
      bad++;
      $display("[TB] FAIL reset_clear got oe=%0b de=%0b hs=%0b vs=%0b rgb=%h%h%h exp 0 0 1 1 000",
               fb.oe, de, h_sync, v_sync, red, green, blue);
    end
    repeat (2) @(negedge pclk);
    reset_n = 1'b1;
    @(posedge pclk);
    @(negedge pclk);
    total++;
    if ({fb.oe, fb.rAddr, de} !== {1'b1, 17'd0, 1'b0}) begin
      bad++; $display("[TB] FAIL reset_cyc0 got oe=%0b addr=%0d de=%0b exp 1 0 0", fb.oe, fb.rAddr, de);
    end
    @(negedge pclk);
    total++;
    if ({de, frame_start} !== 2'b00) begin
      bad++; $display("[TB] FAIL reset_cyc1 got de=%0b fs=%0b exp 0 0", de, frame_start);
    end
    @(negedge pclk);
    total++;
    if ({de, frame_start, x_pixel, y_pixel} !== {1'b1, 1'b1, 10'd0, 10'd0}) begin
      bad++; $display("[TB] FAIL reset_cyc2 got de=%0b fs=%0b x=%0d y=%0d exp 1 1 0 0",
                      de, frame_start, x_pixel, y_pixel);
    end
  endtask

  task automatic test_addressing();
    int errs, first_bad, h, v;
    logic        exp_oe;
    logic [16:0] exp_addr, first_got;
    errs = 0; first_bad = -1; first_got = '0;
    mem_mode = 0;
    start_scan();
    while (cyc <= 7 * 800 + 639) begin
      h = cyc % 800;
      v = cyc / 800;
      exp_oe   = (h < 640);
      exp_addr = exp_oe ? 17'((v / 2) * 320 + h / 2) : 17'd0;
      if ({fb.oe, fb.rAddr} !== {exp_oe, exp_addr}) begin
        errs++;
        if (first_bad < 0) begin first_bad = cyc; first_got = fb.rAddr; end
      end
      if (cyc == 1) begin
        total++;
        if (fb.rAddr !== 17'd0) begin bad++; $display("[TB] FAIL addr_dup_col1 got=%0d exp=0", fb.rAddr); end
      end
      if (cyc == 639) begin
        total++;
        if (fb.rAddr !== 17'd319) begin bad++; $display("[TB] FAIL addr_row0_end got=%0d exp=319", fb.rAddr); end
      end
      if (cyc == 800) begin
        total++;
        if (fb.rAddr !== 17'd0) begin bad++; $display("[TB] FAIL addr_row1_start got=%0d exp=0", fb.rAddr); end
      end
      if (cyc == 1600) begin
        total++;
        if (fb.rAddr !== 17'd320) begin bad++; $display("[TB] FAIL addr_row2_start got=%0d exp=320", fb.rAddr); end
      end
      if (cyc == 7 * 800 + 639) begin
        total++;
        if (fb.rAddr !== 17'd1279) begin bad++; $display("[TB] FAIL addr_last got=%0d exp=1279", fb.rAddr); end
      end
      @(negedge pclk);
      cyc++;
    end
    total++;
    if (errs !== 0) begin
      bad++; $display("[TB] FAIL addr_scan errors=%0d first_cycle=%0d got_addr=%0d", errs, first_bad, first_got);
    end
  endtask

  task automatic test_data_path();
    int errs;
    errs = 0;
    mem_mode = 1;
    start_scan();
    go_to(12);
    total++;
    if ({de, red, green, blue} !== {1'b1, 4'hF, 4'h0, 4'hF}) begin
      bad++; $display("[TB] FAIL data_f81f got de=%0b rgb=%h%h%h exp 1 f0f", de, red, green, blue);
    end
    while (cyc <= 641) begin
      if ({de, red, green, blue} !== {1'b1, 4'hF, 4'h0, 4'hF}) errs++;
      @(negedge pclk);
      cyc++;
    end
    total++;
    if (errs !== 0) begin bad++; $display("[TB] FAIL data_line errors=%0d exp=0", errs); end
    total++;
    if (de !== 1'b0) begin bad++; $display("[TB] FAIL data_de_fall got=%0b exp=0", de); end
    mem_mode = 2;
    go_to(700);
    total++;
    if ({de, red, green, blue} !== {1'b0, 12'h000}) begin
      bad++; $display("[TB] FAIL data_blank_ffff got de=%0b rgb=%h%h%h exp 0 000", de, red, green, blue);
    end
    go_to(802);
    total++;
    if ({de, red, green, blue} !== {1'b1, 12'hFFF}) begin
      bad++; $display("[TB] FAIL data_ffff got de=%0b rgb=%h%h%h exp 1 fff", de, red, green, blue);
    end
    // Pixel (200,2) reads address 420 = 16'h01A4 -> r=0 g=3 b=2.
    mem_mode = 0;
    start_scan();
    go_to(1802);
    total++;
    if ({de, x_pixel, y_pixel, red, green, blue} !== {1'b1, 10'd200, 10'd2, 4'h0, 4'h3, 4'h2}) begin
      bad++; $display("[TB] FAIL data_pix_200_2 got de=%0b x=%0d y=%0d rgb=%h%h%h exp 1 200 2 032",
                      de, x_pixel, y_pixel, red, green, blue);
    end
    go_to(1803);
    total++;
    if ({x_pixel, red, green, blue} !== {10'd201, 4'h0, 4'h3, 4'h2}) begin
      bad++; $display("[TB] FAIL data_pix_201_2 got x=%0d rgb=%h%h%h exp 201 032", x_pixel, red, green, blue);
    end
    go_to(2602);
    total++;
    if ({y_pixel, red, green, blue} !== {10'd3, 4'h0, 4'h3, 4'h2}) begin
      bad++; $display("[TB] FAIL data_pix_200_3 got y=%0d rgb=%h%h%h exp 3 032", y_pixel, red, green, blue);
    end
  endtask

  task automatic test_timing();
    logic de_p, hs_p, vs_p;
    int first_rise, last_rise, n_lines, line_errs, run_errs, pos_errs;
    int hs_fall, n_hs, hs_off_errs, hs_len_errs, vs_fall, vs_len, fs_cnt, fs_first, fs_gap, de_cycles;
    first_rise = -1; last_rise = -1; n_lines = 0; line_errs = 0; run_errs = 0; pos_errs = 0;
    hs_fall = 0; n_hs = 0; hs_off_errs = 0; hs_len_errs = 0; vs_fall = -1; vs_len = -1;
    fs_cnt = 0; fs_first = -1; fs_gap = -1; de_cycles = 0;
    mem_mode = 0;
    start_scan();
    de_p = 1'b0; hs_p = 1'b1; vs_p = 1'b1;
    while (cyc <= FRAME + 10) begin
      if (de && !de_p && cyc < FRAME + 2) begin
        if (first_rise < 0) first_rise = cyc;
        else if (cyc - last_rise != 800) line_errs++;
        last_rise = cyc;
        n_lines++;
      end
      if (de && cyc < FRAME + 2) begin
        de_cycles++;
        if (int'(x_pixel) != cyc - last_rise || int'(y_pixel) != n_lines - 1) pos_errs++;
      end
      if (!de && de_p && cyc - last_rise != 640) run_errs++;
      if (!h_sync && hs_p) begin
        n_hs++;
        hs_fall = cyc;
        if ((cyc - first_rise) % 800 != 656) hs_off_errs++;
      end
      if (h_sync && !hs_p && cyc - hs_fall != 96) hs_len_errs++;
      if (!v_sync && vs_p) vs_fall = cyc;
      if (v_sync && !vs_p) vs_len = cyc - vs_fall;
      if (frame_start) begin
        fs_cnt++;
        if (fs_first < 0) fs_first = cyc;
        else fs_gap = cyc - fs_first;
      end
      de_p = de; hs_p = h_sync; vs_p = v_sync;
      @(negedge pclk);
      cyc++;
    end
    total++;
    if (n_lines != V_VIS) begin bad++; $display("[TB] FAIL tim_lines got=%0d exp=%0d", n_lines, V_VIS); end
    total++;
    if (line_errs != 0) begin bad++; $display("[TB] FAIL tim_line_period errors=%0d exp=0", line_errs); end
    total++;
    if (run_errs != 0) begin bad++; $display("[TB] FAIL tim_de_640 errors=%0d exp=0", run_errs); end
    total++;
    if (de_cycles != 640 * V_VIS) begin bad++; $display("[TB] FAIL tim_de_cycles got=%0d exp=%0d", de_cycles, 640 * V_VIS); end
    total++;
    if (pos_errs != 0) begin bad++; $display("[TB] FAIL tim_xy errors=%0d exp=0", pos_errs); end
    total++;
    if (n_hs != 15 || hs_off_errs != 0 || hs_len_errs != 0) begin
      bad++; $display("[TB] FAIL tim_hsync got falls=%0d off_err=%0d len_err=%0d exp 15 0 0", n_hs, hs_off_errs, hs_len_errs);
    end
    total++;
    if (vs_fall != 8002 || vs_len != 1600) begin
      bad++; $display("[TB] FAIL tim_vsync got fall=%0d len=%0d exp 8002 1600", vs_fall, vs_len);
    end
    total++;
    if (fs_cnt != 2 || fs_first != 2 || fs_gap != FRAME) begin
      bad++; $display("[TB] FAIL tim_frame_start got cnt=%0d first=%0d gap=%0d exp 2 2 %0d", fs_cnt, fs_first, fs_gap, FRAME);
    end
  endtask

  task automatic test_mid_frame_reset();
    mem_mode = 1;
    start_scan();
    go_to(5 * 800 + 300);
    total++;
    if ({de, x_pixel, y_pixel} !== {1'b1, 10'd298, 10'd5}) begin
      bad++; $display("[TB] FAIL mid_pre got de=%0b x=%0d y=%0d exp 1 298 5", de, x_pixel, y_pixel);
    end
    reset_n = 1'b0;
    #1;
    total++;
    if ({fb.oe, fb.rAddr, de, h_sync, v_sync, red, green, blue, x_pixel, y_pixel, frame_start} !==
        {1'b0, 17'd0, 1'b0, 1'b1, 1'b1, 12'h000, 10'd0, 10'd0, 1'b0}) begin
      bad++; $display("[TB] FAIL mid_clear got oe=%0b addr=%0d de=%0b hs=%0b vs=%0b rgb=%h%h%h x=%0d y=%0d fs=%0b",
                      fb.oe, fb.rAddr, de, h_sync, v_sync, red, green, blue, x_pixel, y_pixel, frame_start);
    end
    repeat (3) @(negedge pclk);
    total++;
    if ({fb.oe, de} !== 2'b00) begin bad++; $display("[TB] FAIL mid_held got oe=%0b de=%0b exp 0 0", fb.oe, de); end
    reset_n = 1'b1;
    @(posedge pclk);
    @(negedge pclk);
    total++;
    if ({fb.oe, fb.rAddr, de} !== {1'b1, 17'd0, 1'b0}) begin
      bad++; $display("[TB] FAIL mid_cyc0 got oe=%0b addr=%0d de=%0b exp 1 0 0", fb.oe, fb.rAddr, de);
    end
    repeat (2) @(negedge pclk);
    total++;
    if ({de, frame_start, x_pixel, y_pixel, red, green, blue} !== {1'b1, 1'b1, 10'd0, 10'd0, 12'hF0F}) begin
      bad++; $display("[TB] FAIL mid_cyc2 got de=%0b fs=%0b x=%0d y=%0d rgb=%h%h%h exp 1 1 0 0 f0f",
                      de, frame_start, x_pixel, y_pixel, red, green, blue);
    end
  endtask

  initial begin
    fb.rData = 16'h0000;
    test_reset();
    test_addressing();
    test_data_path();
    test_timing();
    test_mid_frame_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
